psum_accum_buf: RTL and testbench

//  Partial-sum scratchpad and accumulation controller downstream of the PE multiply-add unit.

---
 rtl/psum_accum_buf_pkg.sv | 14 +
 rtl/psum_spad.sv | 42 ++++
 rtl/psum_accum_buf.sv | 162 ++++++++++++++++
 tb/tb_psum_accum_buf.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_buf_pkg.sv
// Shared definitions for the partial-sum accumulation buffer.
// Holds the default psum width, the default depth and the controller state encoding.
package psum_accum_buf_pkg;

  localparam int PSUM_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/psum_spad.sv
// Psum scratchpad: DEPTH x PSUM_WIDTH flop array with one combinational read port
// and one synchronous write port. Out-of-range addresses read as 0 and never write.
module psum_spad #(
  parameter int PSUM_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [PSUM_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [PSUM_WIDTH-1:0] wr_data
);

  logic [PSUM_WIDTH-1:0] mem_q [DEPTH];
  logic                  rd_ok;
  logic                  wr_ok;

  assign rd_ok = {1'b0, rd_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign wr_ok = {1'b0, wr_addr} < (ADDR_WIDTH+1)'(DEPTH);

  // NOTE: the array is reset and cleared on purpose: accumulation and drain both
  // rely on every entry starting at zero, which a RAM macro could not guarantee.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en && wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok) rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/psum_accum_buf.sv
// Partial-sum accumulation controller: feeds the multiply-add accumulate operand, writes its
// 1-cycle-late result back, merges a neighbour psum stream and drains entries over valid/ready.
module psum_accum_buf
  import psum_accum_buf_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  mac_valid,
  input  logic [ADDR_WIDTH-1:0] mac_addr,
  input  logic                  mac_first,
  output logic [PSUM_WIDTH-1:0] ma_add_a,
  output logic [PSUM_WIDTH-1:0] ma_add_b,
  output logic                  ma_sel_b,
  input  logic [PSUM_WIDTH-1:0] ma_result,
  input  logic                  psum_in_start,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  input  logic [PSUM_WIDTH-1:0] psum_in_data,
  input  logic                  drain_start,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [PSUM_WIDTH-1:0] psum_out_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  wr_mac_q, wr_mac_d;   // pending write came from a MAC, not a merge beat
  logic                  last_q, last_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PSUM_WIDTH-1:0] rd_data;
  logic                  mac_in_range;
  logic                  fwd;

  assign rd_addr      = (state_q == ST_IDLE) ? mac_addr : ptr_q;
  assign mac_in_range = {1'b0, mac_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign fwd          = wr_pend_q && mac_valid && mac_in_range && (mac_addr == wr_addr_q);
  assign busy         = (state_q != ST_IDLE) || wr_pend_q;
  assign done         = done_q;

  psum_spad #(
    .PSUM_WIDTH (PSUM_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_spad (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_pend_q),
    .wr_addr (wr_addr_q),
    .wr_data (ma_result)
  );

  // NOTE: every output and next-state signal gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    wr_addr_d      = wr_addr_q;
    wr_pend_d      = 1'b0;
    wr_mac_d       = 1'b0;
    last_d         = 1'b0;
    done_d         = last_q;
    ma_add_a       = '0;
    ma_add_b       = '0;
    ma_sel_b       = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    psum_out_data  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (mac_valid) begin
          ma_add_a  = mac_first ? '0 : (fwd ? ma_result : rd_data);
          wr_pend_d = 1'b1;
          wr_mac_d  = 1'b1;
          wr_addr_d = mac_addr;
        end
        if (drain_start)        state_d = ST_DRAIN;
        else if (psum_in_start) state_d = ST_MERGE;
      end
      ST_MERGE: begin
        psum_in_ready = !(wr_pend_q && wr_mac_q);
        if (psum_in_valid && psum_in_ready) begin
          ma_sel_b  = 1'b1;
          ma_add_a  = rd_data;
          ma_add_b  = psum_in_data;
          wr_pend_d = 1'b1;
          wr_addr_d = ptr_q;
          if (ptr_q == LAST_PTR) begin
            ptr_d   = '0;
            last_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        psum_out_valid = !wr_pend_q;
        psum_out_data  = rd_data;
        if (psum_out_valid && psum_out_ready) begin
          if (ptr_q == LAST_PTR) begin
            ptr_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear aborts everything, including a write already in flight.
    if (clear) begin
      state_d   = ST_IDLE;
      ptr_d     = '0;
      wr_pend_d = 1'b0;
      wr_mac_d  = 1'b0;
      last_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_pend_q <= 1'b0;
      wr_mac_q  <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_pend_q <= wr_pend_d;
      wr_mac_q  <= wr_mac_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_buf.sv
// Self-checking bench for psum_accum_buf: acts as the multiply-add unit and keeps a
// per-entry array of the values each psum should logically hold.
module tb_psum_accum_buf;

  localparam int DEPTH = 8;
  localparam int PW    = 16;
  localparam int AW    = 3;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          mac_valid;
  logic [AW-1:0] mac_addr;
  logic          mac_first;
  logic [PW-1:0] ma_add_a;
  logic [PW-1:0] ma_add_b;
  logic          ma_sel_b;
  logic [PW-1:0] ma_result;
  logic          psum_in_start;
  logic          psum_in_valid;
  logic          psum_in_ready;
  logic [PW-1:0] psum_in_data;
  logic          drain_start;
  logic          psum_out_valid;
  logic          psum_out_ready;
  logic [PW-1:0] psum_out_data;
  logic          busy;
  logic          done;

  logic [PW-1:0] model_q [DEPTH];
  logic [PW-1:0] prod;
  int            checks;
  int            failures;
  int            beat;
  int            cyc;
  bit            prev_v;
  bit            v;
  int            addr;

  psum_accum_buf #(.PSUM_WIDTH(PW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .mac_valid      (mac_valid),
    .mac_addr       (mac_addr),
    .mac_first      (mac_first),
    .ma_add_a       (ma_add_a),
    .ma_add_b       (ma_add_b),
    .ma_sel_b       (ma_sel_b),
    .ma_result      (ma_result),
    .psum_in_start  (psum_in_start),
    .psum_in_valid  (psum_in_valid),
    .psum_in_ready  (psum_in_ready),
    .psum_in_data   (psum_in_data),
    .drain_start    (drain_start),
    .psum_out_valid (psum_out_valid),
    .psum_out_ready (psum_out_ready),
    .psum_out_data  (psum_out_data),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Multiply-add unit: result = a + product (MAC) or a + b (add-only), one cycle later.
  task automatic tick();
    logic [PW-1:0] nr;
    nr = ma_sel_b ? ma_add_a + ma_add_b : ma_add_a + prod;
    @(posedge clk);
    #1;
    ma_result = nr;
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model_q[i] = '0;
  endtask

  task automatic mac_step(input bit valid, input int a, input bit first, input logic [PW-1:0] p);
    logic [PW-1:0] exp_a;
    mac_valid = valid;
    mac_addr  = AW'(a);
    mac_first = first;
    prod      = p;
    #1;
    if (valid) begin
      exp_a = first ? '0 : model_q[a];
      check("mac_add_a", ma_add_a, exp_a);
      check("mac_add_b", ma_add_b, 0);
      check("mac_sel_b", ma_sel_b, 0);
      model_q[a] = exp_a + p;
    end
    tick();
  endtask

  task automatic do_drain(input int mode, input bit issue_start);
    int b;
    int c;
    b = 0;
    c = 0;
    mac_valid     = 1'b0;
    psum_in_start = 1'b0;
    if (issue_start) begin
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
    end
    while (b < DEPTH && c < 100) begin
      case (mode)
        0:       psum_out_ready = 1'b1;
        1:       psum_out_ready = (c % 2 == 0);
        default: psum_out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("drain_no_early_done", done, 0);
      if (psum_out_valid) begin
        check($sformatf("drain_data[%0d]", b), psum_out_data, model_q[b]);
        if (psum_out_ready) b++;
      end
      c++;
      tick();
    end
    check("drain_beats", b, DEPTH);
    psum_out_ready = 1'b0;
    #1;
    check("drain_done", done, 1);
    check("drain_valid_after", psum_out_valid, 0);
    check("drain_busy_after", busy, 0);
    tick();
    #1;
    check("drain_done_pulse", done, 0);
  endtask

  task automatic merge_beats(input bit kp1);
    int k;
    int c;
    logic [PW-1:0] d;
    k = 0;
    c = 0;
    while (k < DEPTH && c < 100) begin
      psum_in_valid = ($urandom_range(0, 3) != 0);
      d = kp1 ? PW'(k + 1) : PW'($urandom);
      psum_in_data = d;
      #1;
      check("merge_ready", psum_in_ready, 1);
      if (psum_in_valid) begin
        check("merge_sel_b", ma_sel_b, 1);
        check($sformatf("merge_add_a[%0d]", k), ma_add_a, model_q[k]);
        check("merge_add_b", ma_add_b, d);
        model_q[k] = model_q[k] + d;
        k++;
      end else begin
        check("merge_stall_sel_b", ma_sel_b, 0);
      end
      c++;
      tick();
    end
    check("merge_beats", k, DEPTH);
    psum_in_valid = 1'b0;
    #1;
    check("merge_done_wait", done, 0);
    check("merge_ready_after", psum_in_ready, 0);
    check("merge_busy_wr", busy, 1);
    tick();
    #1;
    check("merge_done", done, 1);
    check("merge_busy_after", busy, 0);
    tick();
    #1;
    check("merge_done_pulse", done, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    mac_valid = 1'b0;
    mac_addr = '0;
    mac_first = 1'b0;
    ma_result = '0;
    psum_in_start = 1'b0;
    psum_in_valid = 1'b0;
    psum_in_data = '0;
    drain_start = 1'b0;
    psum_out_ready = 1'b0;
    prod = '0;
    model_zero();

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", psum_in_ready, 0);
    check("rst_out_valid", psum_out_valid, 0);
    check("rst_sel_b", ma_sel_b, 0);
    check("rst_add_a", ma_add_a, 0);
    check("rst_add_b", ma_add_b, 0);
    #6 rst_n = 1'b1;
    tick();

    // Back-to-back MACs into entry 2 use the forwarded result
    mac_step(1, 2, 1, 16'd6);
    mac_step(1, 2, 0, 16'd7);
    check("fwd_busy", busy, 1);
    mac_step(0, 0, 0, 16'd0);
    do_drain(0, 1);

    // Randomized MAC traffic, biased toward repeated addresses
    prev_v = 0;
    addr = 0;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) addr = $urandom_range(0, DEPTH - 1);
      mac_step(v, addr, ($urandom_range(0, 4) == 0), PW'($urandom));
      check("mac_busy", busy, v);
    end
    mac_step(0, 0, 0, 16'd0);
    do_drain(2, 1);

    // Merge: entries k*10, beats k+1; merge start alongside the last load MAC
    for (int k = 0; k < DEPTH - 1; k++) mac_step(1, k, 1, PW'(k * 10));
    psum_in_start = 1'b1;
    mac_step(1, DEPTH - 1, 1, PW'((DEPTH - 1) * 10));
    psum_in_start = 1'b0;
    mac_valid = 1'b0;
    psum_in_valid = 1'b1;
    psum_in_data = 16'd1;
    #1;
    check("merge_ready_wr_pend", psum_in_ready, 0);
    check("merge_no_beat_sel_b", ma_sel_b, 0);
    tick();
    merge_beats(1);
    for (int k = 0; k < DEPTH; k++) check("merge_model_11k1", model_q[k], 32'(11 * k + 1));
    do_drain(1, 1);

    // Both starts together: drain wins; merge start during drain ignored
    drain_start = 1'b1;
    psum_in_start = 1'b1;
    tick();
    drain_start = 1'b0;
    psum_out_ready = 1'b0;
    #1;
    check("both_start_valid", psum_out_valid, 1);
    check("both_start_ready", psum_in_ready, 0);
    tick();
    psum_in_start = 1'b0;
    #1;
    check("drain_ignores_merge", psum_in_ready, 0);
    do_drain(2, 0);

    // drain_start during merge ignored
    psum_in_start = 1'b1;
    tick();
    psum_in_start = 1'b0;
    drain_start = 1'b1;
    psum_in_valid = 1'b0;
    #1;
    check("merge_ignores_drain_valid", psum_out_valid, 0);
    tick();
    drain_start = 1'b0;
    #1;
    check("merge_still_ready", psum_in_ready, 1);
    check("merge_still_no_valid", psum_out_valid, 0);
    merge_beats(0);
    do_drain(0, 1);

    // Async reset at drain beat 3
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    psum_out_ready = 1'b1;
    beat = 0;
    cyc = 0;
    while (beat < 3 && cyc < 50) begin
      #1;
      if (psum_out_valid) begin
        check("rst_drain_data", psum_out_data, model_q[beat]);
        beat++;
      end
      cyc++;
      tick();
    end
    check("rst_drain_beats", beat, 3);
    #1;
    check("rst_drain_valid_pre", psum_out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_drain_valid", psum_out_valid, 0);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_done", done, 0);
    #2 rst_n = 1'b1;
    psum_out_ready = 1'b0;
    model_zero();
    tick();
    #1;
    check("rst_no_done", done, 0);
    check("rst_idle", busy, 0);
    do_drain(0, 1);

    // Clear mid-merge, with a beat offered in the clear cycle
    for (int k = 0; k < DEPTH; k++) mac_step(1, k, 1, PW'($urandom));
    mac_step(0, 0, 0, 16'd0);
    psum_in_start = 1'b1;
    tick();
    psum_in_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      psum_in_valid = 1'b1;
      psum_in_data = PW'($urandom);
      #1;
      check("clr_merge_add_a", ma_add_a, model_q[k]);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    psum_in_valid = 1'b0;
    model_zero();
    #1;
    check("clr_busy", busy, 0);
    check("clr_ready", psum_in_ready, 0);
    check("clr_done", done, 0);
    tick();
    #1;
    check("clr_no_done", done, 0);
    do_drain(0, 1);

    // Overflow wraps; mac_first ignores the stale entry
    mac_step(1, 0, 1, 16'h7FFF);
    mac_step(0, 0, 0, 16'd0);
    mac_step(1, 0, 0, 16'h0001);
    mac_step(0, 0, 0, 16'd0);
    check("ovf_model", model_q[0], 32'h8000);
    do_drain(0, 1);
    mac_step(1, 0, 1, 16'h0005);
    mac_step(0, 0, 0, 16'd0);
    do_drain(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
